// File: rtl/uart_frame_ctrl.sv
// Byte-stream frame controller: captures UART bytes, soft-resets the receiver, parses
// SYNC/LEN/payload/CSUM frames into a buffer and hands them to a consumer via ready/ack.
module uart_frame_ctrl #(
  parameter int unsigned CLOCK_FREQ    = 38400000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_soft_reset,
  output logic        frame_ready,
  output logic [4:0]  frame_len,
  input  logic [4:0]  rd_addr,
  output logic [7:0]  rd_data,
  input  logic        frame_ack,
  output logic        err_checksum,
  output logic        err_length,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic [15:0] frame_count
);

  localparam int unsigned TimeoutCycles = TIMEOUT_BYTES * 10 * (CLOCK_FREQ / BAUD_RATE);
  localparam int unsigned CntW          = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast   = CntW'(TimeoutCycles - 1);
  localparam logic [7:0] MaxLenByte     = 8'(MAX_LEN);
  localparam logic [5:0] MaxLenAddr     = 6'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StLen, StPayload, StCsum, StReady} state_e;

  state_e          state_q;
  logic            rx_valid_q;
  logic [CntW-1:0] cnt_q;
  logic [4:0]      len_q;
  logic [4:0]      idx_q;
  logic [7:0]      acc_q;
  logic [7:0]      mem_q [32];

  logic cap;
  logic in_frame;
  logic expire;

  always_comb begin
    cap      = rx_valid & ~rx_valid_q;
    in_frame = (state_q == StLen) || (state_q == StPayload) || (state_q == StCsum);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    expire   = in_frame & ~cap & (cnt_q == CntLast);
  end

  // Frame buffer has no reset; it is written only while collecting payload.
  always_ff @(posedge clk) begin
    if (state_q == StPayload && cap) begin
      mem_q[idx_q] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rx_valid_q    <= 1'b0;
      cnt_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      rx_soft_reset <= 1'b0;
      frame_ready   <= 1'b0;
      frame_len     <= '0;
      rd_data       <= '0;
      err_checksum  <= 1'b0;
      err_length    <= 1'b0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;
      frame_count   <= '0;
    end else begin
      rx_valid_q    <= rx_valid;
      rx_soft_reset <= cap;
      err_checksum  <= 1'b0;
      err_length    <= 1'b0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;
      rd_data       <= ({1'b0, rd_addr} < MaxLenAddr) ? mem_q[rd_addr] : 8'h00;

      // Every state change in or out of the frame states coincides with a capture or expiry.
      if (!in_frame || cap || expire) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (cap && rx_data == SYNC_BYTE) begin
            state_q <= StLen;
          end
        end
        StLen: begin
          if (cap) begin
            if (rx_data == 8'h00 || rx_data > MaxLenByte) begin
              err_length <= 1'b1;
              state_q    <= StIdle;
            end else begin
              len_q   <= rx_data[4:0];
              acc_q   <= rx_data;
              idx_q   <= '0;
              state_q <= StPayload;
            end
          end else if (expire) begin
            err_timeout <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StPayload: begin
          if (cap) begin
            acc_q <= acc_q + rx_data;
            idx_q <= idx_q + 5'd1;
            if (idx_q == len_q - 5'd1) begin
              state_q <= StCsum;
            end
          end else if (expire) begin
            err_timeout <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StCsum: begin
          if (cap) begin
            if (rx_data == acc_q) begin
              frame_ready <= 1'b1;
              frame_len   <= len_q;
              frame_count <= frame_count + 16'd1;
              state_q     <= StReady;
            end else begin
              err_checksum <= 1'b1;
              state_q      <= StIdle;
            end
          end else if (expire) begin
            err_timeout <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StReady: begin
          if (cap) begin
            err_overrun <= 1'b1;
          end
          if (frame_ack) begin
            frame_ready <= 1'b0;
            frame_len   <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Randomised bench for uart_frame_ctrl with a queue-based frame reference model
// checked every cycle, plus directed scenarios pinned with literal expectations.
module tb_uart_frame_ctrl;

  localparam int unsigned ClkFreq = 96000;
  localparam int unsigned Baud    = 9600;
  localparam int unsigned MaxLen  = 16;
  localparam int unsigned ToBytes = 4;
  localparam int unsigned To      = ToBytes * 10 * (ClkFreq / Baud);

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_soft_reset;
  logic        frame_ready;
  logic [4:0]  frame_len;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        frame_ack;
  logic        err_checksum;
  logic        err_length;
  logic        err_timeout;
  logic        err_overrun;
  logic [15:0] frame_count;

  uart_frame_ctrl #(
    .CLOCK_FREQ   (ClkFreq),
    .BAUD_RATE    (Baud),
    .MAX_LEN      (MaxLen),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_BYTES(ToBytes)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_soft_reset(rx_soft_reset),
    .frame_ready  (frame_ready),
    .frame_len    (frame_len),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_ack    (frame_ack),
    .err_checksum (err_checksum),
    .err_length   (err_length),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the queue of bytes seen after a sync byte.
  logic        m_pv;
  logic        m_in_frame;
  logic        m_ready;
  int          m_len;
  int          m_idle;
  logic [15:0] m_count;
  logic [7:0]  m_q [$];
  logic [7:0]  m_mem [32];
  logic        e_srst, e_ready, e_cks, e_lerr, e_to, e_ovr, e_rd_chk;
  logic [4:0]  e_len;
  logic [7:0]  e_rd;
  logic [15:0] e_count;
  int n_srst = 0, n_cks = 0, n_lerr = 0, n_to = 0, n_ovr = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_pv = 0; m_in_frame = 0; m_ready = 0; m_len = 0; m_idle = 0; m_count = 0;
      m_q.delete();
      {e_srst, e_ready, e_cks, e_lerr, e_to, e_ovr} = '0;
      e_len = 0; e_rd = 0; e_rd_chk = 1; e_count = 0;
      chk("rst_outputs", {rx_soft_reset, frame_ready, err_checksum, err_length, err_timeout,
                          err_overrun}, 0);
      chk("rst_len", frame_len, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_count", frame_count, 0);
    end else begin
      chk("soft_reset", rx_soft_reset, e_srst);
      chk("frame_ready", frame_ready, e_ready);
      if (e_ready) chk("frame_len", frame_len, e_len);
      chk("err_checksum", err_checksum, e_cks);
      chk("err_length", err_length, e_lerr);
      chk("err_timeout", err_timeout, e_to);
      chk("err_overrun", err_overrun, e_ovr);
      chk("frame_count", frame_count, e_count);
      if (e_rd_chk) chk("rd_data", rd_data, e_rd);
      n_srst += rx_soft_reset; n_cks += err_checksum; n_lerr += err_length;
      n_to += err_timeout; n_ovr += err_overrun;
      model_step();
    end
  end

  task automatic model_step();
    logic cap;
    logic [7:0] b;
    int n, s;
    cap  = rx_valid && !m_pv;
    m_pv = rx_valid;
    b    = rx_data;
    {e_cks, e_lerr, e_to, e_ovr} = '0;
    e_srst   = cap;
    e_rd     = (rd_addr >= MaxLen) ? 8'h00 : m_mem[rd_addr];
    e_rd_chk = (rd_addr >= MaxLen) || (m_ready && rd_addr < m_len);
    if (m_ready) begin
      if (cap) e_ovr = 1;
      if (frame_ack) m_ready = 0;
    end else if (!m_in_frame) begin
      if (cap && b == 8'hA5) begin
        m_in_frame = 1; m_idle = 0; m_q.delete();
      end
    end else if (cap) begin
      m_idle = 0;
      m_q.push_back(b);
      n = m_q.size();
      if (n == 1) begin
        if (b == 0 || b > MaxLen) begin e_lerr = 1; m_in_frame = 0; end
      end else if (n <= m_q[0] + 1) begin
        m_mem[n-2] = b;
      end else begin
        s = 0;
        for (int i = 0; i < n - 1; i++) s += m_q[i];
        if ((s % 256) == b) begin
          m_ready = 1; m_len = m_q[0]; m_count = m_count + 16'd1;
        end else begin
          e_cks = 1;
        end
        m_in_frame = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == To) begin e_to = 1; m_in_frame = 0; end
    end
    e_ready = m_ready;
    e_len   = 5'(m_len);
    e_count = m_count;
    chk("err_onehot", ($countones({err_checksum, err_length, err_timeout, err_overrun}) <= 1), 1);
  endtask

  // Stimulus
  logic       rand_rd = 0;
  logic       rnd_timing = 0;
  logic [7:0] seq [$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_rd) rd_addr = 5'($urandom);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_valid = 1; rx_data = b;
    tick(hold);
    rx_valid = 0; rx_data = 8'($urandom);
    tick(gap);
  endtask

  task automatic send_seq();
    foreach (seq[i]) begin
      if (rnd_timing) send_byte(seq[i], $urandom_range(1, 3), $urandom_range(1, 5));
      else send_byte(seq[i], 1, 2);
    end
  endtask

  task automatic ack();
    frame_ack = 1; tick(1); frame_ack = 0; tick(1);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
    rd_addr = a; tick(1); chk(name, rd_data, exp);
  endtask

  int s0, c0, l0, t0, o0;

  initial begin
    rst = 1; rx_valid = 0; rx_data = 0; rd_addr = 0; frame_ack = 0;
    tick(3);
    rst = 0;
    tick(2);
    chk("reset_count", frame_count, 0);

    // Good frame
    s0 = n_srst;
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}; send_seq();
    chk("good_ready", frame_ready, 1);
    chk("good_len", frame_len, 3);
    chk("good_count", frame_count, 1);
    chk("good_srst", n_srst - s0, 6);
    rd_chk("good_rd0", 0, 8'h11); rd_chk("good_rd1", 1, 8'h22); rd_chk("good_rd2", 2, 8'h33);
    rd_chk("rd_oob", 5'd20, 8'h00);
    ack();
    chk("ack_ready", frame_ready, 0);

    // Bad checksum then good
    c0 = n_cks;
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68}; send_seq();
    chk("cks_pulse", n_cks - c0, 1);
    chk("cks_ready", frame_ready, 0);
    chk("cks_count", frame_count, 1);
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}; send_seq();
    chk("cks_recover", frame_count, 2);
    ack();

    // Length errors and leading garbage
    l0 = n_lerr;
    seq = '{8'hA5, 8'h00, 8'hA5, 8'h11}; send_seq();
    chk("len_pulses", n_lerr - l0, 2);
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F}; send_seq();
    chk("garbage_ready", frame_ready, 1);
    chk("garbage_len", frame_len, 1);
    rd_chk("garbage_rd0", 0, 8'h7E);
    chk("garbage_count", frame_count, 3);
    // Ack and byte in the same cycle
    o0 = n_ovr;
    frame_ack = 1; rx_valid = 1; rx_data = 8'h55;
    tick(1);
    frame_ack = 0; rx_valid = 0;
    tick(2);
    chk("ack_byte_ovr", n_ovr - o0, 1);
    chk("ack_byte_ready", frame_ready, 0);

    // Timeout
    t0 = n_to;
    seq = '{8'hA5, 8'h02, 8'hAA}; send_seq();
    tick(To + 50);
    chk("timeout_pulse", n_to - t0, 1);
    // Byte on the expiry cycle wins
    t0 = n_to;
    send_byte(8'hA5, 1, 1); send_byte(8'h02, 1, 1); send_byte(8'hAA, 1, To - 1);
    send_byte(8'hBB, 1, 1); send_byte(8'h67, 1, 2);
    chk("expiry_no_to", n_to - t0, 0);
    chk("expiry_ready", frame_ready, 1);
    chk("expiry_len", frame_len, 2);
    chk("expiry_count", frame_count, 4);
    // Overrun leaves the buffer frozen
    o0 = n_ovr;
    send_byte(8'h55, 1, 2);
    chk("overrun_pulse", n_ovr - o0, 1);
    rd_chk("overrun_rd0", 0, 8'hAA);
    rd_chk("overrun_rd1", 1, 8'hBB);
    ack();

    // Held valid counts once
    s0 = n_srst;
    send_byte(8'hA5, 50, 2);
    chk("held_srst", n_srst - s0, 1);
    seq = '{8'h01, 8'h42, 8'h43}; send_seq();
    chk("held_count", frame_count, 5);
    ack();

    // Reset mid-payload
    c0 = n_cks + n_lerr + n_to + n_ovr;
    seq = '{8'hA5, 8'h04, 8'h01, 8'h02}; send_seq();
    rst = 1; tick(3); rst = 0; tick(2);
    chk("rst_no_err", n_cks + n_lerr + n_to + n_ovr - c0, 0);
    chk("rst_count0", frame_count, 0);
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}; send_seq();
    chk("rst_recover", frame_count, 1);
    ack();

    // Randomised traffic
    rand_rd = 1; rnd_timing = 1;
    for (int it = 0; it < 80; it++) begin
      int kind, len, sum;
      logic [7:0] b;
      kind = $urandom_range(0, 5);
      seq.delete();
      if (kind <= 3) begin
        len = $urandom_range(1, MaxLen);
        seq.push_back(8'hA5); seq.push_back(8'(len));
        sum = len;
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom); seq.push_back(b); sum += b;
        end
        b = 8'(sum);
        if (kind == 3) b = b ^ 8'($urandom_range(1, 255));
        seq.push_back(b);
      end else if (kind == 4) begin
        seq.push_back(8'hA5);
        seq.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
      end else begin
        b = 8'($urandom);
        seq.push_back((b == 8'hA5) ? 8'h5A : b);
      end
      send_seq();
      if (frame_ready) begin
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1, 2);
        tick($urandom_range(0, 4));
        if ($urandom_range(0, 2) == 0) begin
          frame_ack = 1; rx_valid = 1; rx_data = 8'($urandom);
          tick(1);
          frame_ack = 0; rx_valid = 0;
          tick(2);
        end else begin
          ack();
        end
      end
    end
    rand_rd = 0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Controller that sequences the UART receiver and turns its byte stream into checked frames.
- Detects each received byte, clears the receiver's valid through its soft-reset input, and hunts for a sync byte.
- Parses a length/payload/checksum frame into an internal buffer and hands complete frames to the consumer through a ready/ack handshake.
- Sits between the UART receiver and the command-decode logic.

Parameters:
- CLOCK_FREQ, 38400000, system clock frequency in Hz.
- BAUD_RATE, 9600, line baud rate; used only for the timeout.
- MAX_LEN, 16, maximum payload length in bytes. Legal range is 1..31.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_BYTES, 4, inter-byte timeout in byte times. Timeout length in cycles = TIMEOUT_BYTES*10*(CLOCK_FREQ/BAUD_RATE).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  receiver valid; level that stays high until the receiver is soft-reset.
- rx_soft_reset  out  1  one-cycle pulse that clears the receiver's valid.
- frame_ready  out  1  a complete, checked frame is held in the buffer.
- frame_len  out  5  payload length of the held frame.
- rd_addr  in  5  buffer read address.
- rd_data  out  8  buffer byte at rd_addr, registered.
- frame_ack  in  1  consumer releases the buffer.
- err_checksum  out  1  one-cycle pulse on checksum mismatch.
- err_length  out  1  one-cycle pulse on an illegal LEN byte.
- err_timeout  out  1  one-cycle pulse on inter-byte timeout.
- err_overrun  out  1  one-cycle pulse when a byte arrives while frame_ready is high.
- frame_count  out  16  count of good frames; wraps at 16'hFFFF.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; timeout counter 0.
  - Buffer contents are don't-care.
  - Reset mid-frame discards the partial frame. No error pulse is issued.
- Byte capture:
  - A byte is captured on a rising edge of rx_valid: rx_valid=1 while the previous-cycle registered rx_valid=0.
  - rx_data is sampled in the capture cycle.
  - rx_soft_reset pulses in the cycle after capture.
  - A valid held high for many cycles counts as exactly one byte.
  - Every captured byte is soft-reset, in every state.
- Frame format: SYNC_BYTE, LEN, then LEN payload bytes, then CSUM.
  - Expected CSUM = (LEN + sum of payload bytes) mod 256, computed in an 8-bit accumulator.
- States:
  - IDLE: a captured byte equal to SYNC_BYTE → LEN. Any other byte is dropped silently and the state stays IDLE.
  - LEN:
    - LEN==0 or LEN>MAX_LEN → pulse err_length, go to IDLE.
    - Otherwise latch LEN, load the accumulator with LEN, clear the write index, go to PAYLOAD.
  - PAYLOAD: each byte is written to buffer[index], added to the accumulator, and index increments. After the LEN-th byte → CSUM.
  - CSUM:
    - Byte equals accumulator → READY. frame_ready=1 and frame_len=LEN from the next cycle; frame_count increments once.
    - Byte differs → pulse err_checksum, go to IDLE.
  - READY:
    - frame_len is stable and the buffer is frozen.
    - Captured bytes are dropped, each pulsing err_overrun.
    - frame_ack=1 → IDLE; frame_ready deasserts the following cycle.
    - A byte captured in the same cycle as frame_ack is dropped and still pulses err_overrun.
- Timeout:
  - The counter runs only in LEN, PAYLOAD and CSUM.
  - It clears on every captured byte and on every state change.
  - Expiry → pulse err_timeout, go to IDLE.
  - A byte captured in the expiry cycle wins: the byte is processed and there is no timeout.
- Read port:
  - rd_data = buffer[rd_addr] one cycle after rd_addr is presented.
  - rd_addr ≥ MAX_LEN returns 8'h00.
  - Reads are legal in any state; data is only meaningful while frame_ready=1.
- Error pulses are mutually exclusive per cycle. Each lasts exactly one cycle.

Test Plan:
- Good frame: bytes A5 03 11 22 33 69 → frame_ready=1, frame_len=3. Reading addr 0,1,2 returns 11,22,33. frame_count=1. Six rx_soft_reset pulses.
- Bad checksum: A5 03 11 22 33 68 → one err_checksum pulse, frame_ready stays 0, frame_count unchanged. A following good frame is then accepted.
- Length errors: A5 00 and A5 11 (17 > 16) → err_length each time, back to IDLE. Leading garbage 00 FF A5 01 7E 7F → garbage dropped silently, frame accepted with len 1 and data 7E.
- Timeout: A5 02 AA, then idle for TIMEOUT_BYTES*10*4000 cycles → single err_timeout, state IDLE. A byte arriving exactly on the expiry cycle → no timeout.
- Overrun/ack: while frame_ready=1, send 55 → err_overrun, buffer unchanged. Assert frame_ack → frame_ready=0 next cycle, and a new frame is accepted.
- Held valid and reset: rx_valid held high for 50 cycles → one capture, one soft reset. Assert rst mid-PAYLOAD → all outputs 0, no error pulse, next frame parses normally.
